// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: request kinds, opcodes, error codes, FIFO payload.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        K_RTYPE = 3'd0,
        K_LW    = 3'd1,
        K_SW    = 3'd2,
        K_BEQ   = 3'd3,
        K_BNE   = 3'd4,
        K_ADDI  = 3'd5,
        K_ORI   = 3'd6,
        K_J     = 3'd7
    } kind_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_REGION   = 2'd3
    } err_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // One buffered word: its address and the encoded instruction.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] instr;
    } fifo_entry_t;

    // Opcode for a request kind.
    function automatic logic [5:0] opcode_of(input kind_e k);
        logic [5:0] op;
        case (k)
            K_RTYPE: op = OP_RTYPE;
            K_LW:    op = OP_LW;
            K_SW:    op = OP_SW;
            K_BEQ:   op = OP_BEQ;
            K_BNE:   op = OP_BNE;
            K_ADDI:  op = OP_ADDI;
            K_ORI:   op = OP_ORI;
            default: op = OP_J;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry output buffer with registered head and synchronous flush.
// Ports: clk, reset (async high), flush_i, push_i/din_i, pop_i,
//        valid_o (head present), full_o (two entries held), dout_o (head entry).
module enc_fifo2
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        push_i,
    input  fifo_entry_t din_i,
    input  logic        pop_i,
    output logic        valid_o,
    output logic        full_o,
    output fifo_entry_t dout_o
);

    logic [1:0]  cnt_q, cnt_d;
    fifo_entry_t head_q, head_d;
    fifo_entry_t tail_q, tail_d;
    logic        pop;

    // Next-state: flush wins; push+pop with one entry replaces the head.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        pop    = pop_i & (cnt_q != 2'd0);
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({push_i, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_d = din_i;
                        cnt_d  = 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        tail_d = din_i;
                        cnt_d  = 2'd2;
                    end
                end
                2'b01: begin
                    head_d = tail_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_d = din_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign dout_o  = head_q;

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns request fields into 32-bit words tagged with
// a running address, checks branch/jump targets, and buffers words in enc_fifo2.
// Ports: clk, reset; request side in_valid/in_ready/in_kind/in_rs/in_rt/in_rd/
// in_shamt/in_funct/in_imm/in_target; base_load/base_addr reload the counter;
// output side out_valid/out_ready/out_instr/out_addr; err_valid/err_code pulse.
module instr_encoder
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [5:0]  in_funct,
    input  logic [15:0] in_imm,
    input  logic [31:0] in_target,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_valid,
    output logic [1:0]  err_code
);

    logic [31:0] pc_q, pc_d;
    logic        live_q;
    logic        err_valid_q, err_valid_d;
    err_e        err_code_q, err_code_d;

    logic [31:0] pc4, diff, offs;
    kind_e       kind;
    err_e        err_c;
    logic [31:0] instr_c;
    logic        accept, push, full;
    fifo_entry_t entry;

    // Encode the request and classify its target against the current pc.
    always_comb begin
        pc4     = pc_q + 32'd4;
        diff    = in_target - pc4;
        offs    = 32'($signed(diff) >>> 2);
        kind    = kind_e'(in_kind);
        err_c   = ERR_NONE;
        instr_c = '0;
        case (kind)
            K_RTYPE: instr_c = {OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct};
            K_BEQ, K_BNE: begin
                instr_c = {opcode_of(kind), in_rs, in_rt, offs[15:0]};
                // Word offset fits 16 bits signed iff its top 17 bits agree.
                if (in_target[1:0] != 2'b00)
                    err_c = ERR_MISALIGN;
                else if (!((offs[31:15] == '0) || (offs[31:15] == '1)))
                    err_c = ERR_RANGE;
            end
            K_J: begin
                instr_c = {OP_J, in_target[27:2]};
                if (in_target[1:0] != 2'b00)
                    err_c = ERR_MISALIGN;
                else if (in_target[31:28] != pc4[31:28])
                    err_c = ERR_REGION;
            end
            default: instr_c = {opcode_of(kind), in_rs, in_rt, in_imm};
        endcase
    end

    // Handshake, counter and error-pulse next state; base_load overrides all.
    always_comb begin
        accept      = in_valid & in_ready;
        push        = accept & (err_c == ERR_NONE);
        pc_d        = pc_q;
        err_valid_d = accept & (err_c != ERR_NONE);
        err_code_d  = err_valid_d ? err_c : ERR_NONE;
        if (base_load)
            pc_d = base_addr;
        else if (push)
            pc_d = pc4;
        entry.addr  = pc_q;
        entry.instr = instr_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= BASE_ADDR;
            live_q      <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            pc_q        <= pc_d;
            live_q      <= 1'b1;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    // No pass-through: readiness depends only on stored occupancy.
    assign in_ready = live_q & ~full & ~base_load;

    fifo_entry_t head;

    enc_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (base_load),
        .push_i  (push),
        .din_i   (entry),
        .pop_i   (out_ready),
        .valid_o (out_valid),
        .full_o  (full),
        .dout_o  (head)
    );

    assign out_instr = head.instr;
    assign out_addr  = head.addr;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed cases plus randomized traffic.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [31:0] in_target;
    logic        base_load;
    logic [31:0] base_addr;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_addr;
    logic        err_valid;
    logic [1:0]  err_code;

    instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .base_load(base_load), .base_addr(base_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    int          err_q[$];
    logic [31:0] pc_m;

    localparam logic [5:0] OPT [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder written from the instruction-format rules.
    function automatic void model(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                  input logic [15:0] imm, input logic [31:0] tgt, input logic [31:0] pc,
                                  output int err, output logic [31:0] w);
        int d, off;
        logic [31:0] base;
        err  = 0;
        w    = '0;
        base = (32'(OPT[k]) << 26) | (32'(rs) << 21) | (32'(rt) << 16);
        case (k)
            3'd0: w = base | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
            3'd3, 3'd4: begin
                if (tgt % 4 != 0) err = 1;
                else begin
                    d   = int'(tgt - (pc + 32'd4));
                    off = d / 4;
                    if (off < -32768 || off > 32767) err = 2;
                    else w = base | (32'(off) & 32'h0000_FFFF);
                end
            end
            3'd7: begin
                if (tgt % 4 != 0) err = 1;
                else if ((tgt >> 28) != ((pc + 32'd4) >> 28)) err = 3;
                else w = (32'd2 << 26) | ((tgt & 32'h0FFF_FFFF) >> 2);
            end
            default: w = base | 32'(imm);
        endcase
    endfunction

    // Offer one request (call at posedge+1); returns at posedge+1 after acceptance.
    task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [31:0] tgt, input bit rnd);
        bit r, done;
        int err;
        logic [31:0] w;
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_target = tgt; in_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) begin
                model(k, rs, rt, rd, sh, fn, imm, tgt, pc_m, err, w);
                if (err != 0) err_q.push_back(err);
                else begin
                    exp_q.push_back({pc_m, w});
                    pc_m = pc_m + 32'd4;
                end
                done = 1'b1;
            end else if (rnd) begin
                #1 out_ready = ($urandom_range(0, 1) == 1);
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted @%0t", $time);
        end
        #1 in_valid = 1'b0;
    endtask

    // Reload the counter with out_ready low (call at posedge+1).
    task automatic do_base_load(input logic [31:0] v);
        out_ready = 1'b0;
        base_load = 1'b1;
        base_addr = v;
        in_valid  = 1'b1;
        in_kind   = 3'd5;
        @(negedge clk);
        chk("bl_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        pc_m = v;
        exp_q.delete();
        #1 base_load = 1'b0;
        in_valid = 1'b0;
        chk("bl_flushed", 64'(out_valid), 64'd0);
    endtask

    // Monitor: pops expected words/errors whenever the DUT presents them.
    task automatic monitor();
        bit          prev_hold = 1'b0;
        logic [63:0] prev_word = '0;
        logic [63:0] e;
        int          ec;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
                continue;
            end
            if (prev_hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_stable", {out_addr, out_instr}, prev_word);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected actual=%h required=none @%0t", {out_addr, out_instr}, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", {out_addr, out_instr}, e);
                end
            end
            prev_hold = out_valid & ~out_ready & ~base_load;
            prev_word = {out_addr, out_instr};
            if (err_valid) begin
                if (err_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL err_unexpected actual=%0d required=none @%0t", err_code, $time);
                end else begin
                    ec = err_q.pop_front();
                    chk("err_code", 64'(err_code), 64'(ec));
                end
            end
        end
    endtask

    int bnd[4] = '{32767, 32768, -32768, -32769};

    initial begin
        logic [2:0]  k;
        logic [31:0] tgt, pc4;
        int          o;
        reset = 1'b1; in_valid = 1'b0; in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_shamt = '0; in_funct = '0; in_imm = '0; in_target = '0; base_load = 1'b0;
        base_addr = '0; out_ready = 1'b1; pc_m = 32'h0;
        fork monitor(); join_none

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_err_valid", 64'(err_valid), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        // RTYPE add $11,$9,$10
        send(3'd0, 5'd9, 5'd10, 5'd11, 5'd0, 6'h20, 16'h0, 32'h0, 1'b0);
        chk("r_latency_valid", 64'(out_valid), 64'd1);
        chk("r_instr", 64'(out_instr), 64'h012A_5820);
        chk("r_addr", 64'(out_addr), 64'h0);

        // Fresh counter, then ADDI / LW
        do_base_load(32'h0);
        out_ready = 1'b1;
        send(3'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 32'h0, 1'b0);
        chk("addi_instr", {out_addr, out_instr}, {32'h0, 32'h2008_0005});
        send(3'd1, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd4, 32'h0, 1'b0);
        chk("lw_instr", {out_addr, out_instr}, {32'h4, 32'h8D09_0004});

        // Backward branch and jump
        send(3'd3, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd0, 32'h4, 1'b0);
        chk("beq_instr", {out_addr, out_instr}, {32'h8, 32'h1109_FFFE});
        send(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0040_0020, 1'b0);
        chk("j_instr", {out_addr, out_instr}, {32'hC, 32'h0810_0008});

        // Misaligned branch: one-cycle pulse, pc unchanged
        send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 32'h6, 1'b0);
        chk("mis_err_valid", 64'(err_valid), 64'd1);
        chk("mis_err_code", 64'(err_code), 64'd1);
        @(posedge clk); #1;
        chk("mis_err_pulse_end", 64'(err_valid), 64'd0);
        send(3'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd1, 32'h0, 1'b0);
        chk("after_err_addr", 64'(out_addr), 64'h10);

        // Out-of-range branch from pc=0
        do_base_load(32'h0);
        out_ready = 1'b1;
        send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0004_0004, 1'b0);
        chk("range_err_valid", 64'(err_valid), 64'd1);
        chk("range_err_code", 64'(err_code), 64'd2);
        @(posedge clk); #1;
        send(3'd6, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'hBEEF, 32'h0, 1'b0);
        chk("after_range_addr", 64'(out_addr), 64'h0);

        // Back-pressure: third request held off while two are buffered
        @(posedge clk); #1 out_ready = 1'b0;
        send(3'd5, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 32'h0, 1'b0);
        send(3'd5, 5'd2, 5'd2, 5'd0, 5'd0, 6'd0, 16'd2, 32'h0, 1'b0);
        in_kind = 3'd5; in_rs = 5'd3; in_rt = 5'd3; in_imm = 16'd3; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", 64'(in_ready), 64'd0);
            chk("full_head_addr", 64'(out_addr), 64'h4);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(3'd5, 5'd3, 5'd3, 5'd0, 5'd0, 6'd0, 16'd3, 32'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1 chk("drain_empty", 64'(out_valid), 64'd0);

        // base_load while two words are buffered
        out_ready = 1'b0;
        send(3'd5, 5'd4, 5'd4, 5'd0, 5'd0, 6'd0, 16'd4, 32'h0, 1'b0);
        send(3'd5, 5'd5, 5'd5, 5'd0, 5'd0, 6'd0, 16'd5, 32'h0, 1'b0);
        do_base_load(32'h0040_0000);
        out_ready = 1'b1;
        send(3'd5, 5'd6, 5'd6, 5'd0, 5'd0, 6'd0, 16'd6, 32'h0, 1'b0);
        chk("bl_next_addr", 64'(out_addr), 64'h0040_0000);

        // Reset mid-operation discards buffered words
        @(posedge clk); #1 out_ready = 1'b0;
        send(3'd5, 5'd7, 5'd7, 5'd0, 5'd0, 6'd0, 16'd7, 32'h0, 1'b0);
        send(3'd5, 5'd8, 5'd8, 5'd0, 5'd0, 6'd0, 16'd8, 32'h0, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        err_q.delete();
        pc_m = 32'h0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        send(3'd5, 5'd9, 5'd9, 5'd0, 5'd0, 6'd0, 16'd9, 32'h0, 1'b0);
        chk("post_rst_addr", 64'(out_addr), 64'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 2))
                    0:       do_base_load(32'hFFFF_FFF0);
                    1:       do_base_load(32'h0FFF_FFF8);
                    default: do_base_load($urandom & 32'hFFFF_FFFC);
                endcase
            end
            out_ready = ($urandom_range(0, 3) != 0);
            k   = 3'($urandom_range(0, 7));
            pc4 = pc_m + 32'd4;
            case ($urandom_range(0, 4))
                0: begin
                    o   = int'($urandom_range(0, 200)) - 100;
                    tgt = pc4 + 32'(o * 4);
                end
                1:       tgt = pc4 + 32'(bnd[$urandom_range(0, 3)] * 4);
                2:       tgt = $urandom;
                3:       tgt = {pc4[31:28], 28'($urandom)} & 32'hFFFF_FFFC;
                default: tgt = $urandom & 32'hFFFF_FFFC;
            endcase
            send(k, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                 16'($urandom), tgt, 1'b1);
        end

        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("final_words_drained", 64'(exp_q.size()), 64'd0);
        chk("final_errs_seen", 64'(err_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the address of the first emitted instruction after reset.
REQ-002 SHALL have ports in this order:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted when in_valid & in_ready.
- in_kind  input  3  0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=BNE, 5=ADDI, 6=ORI, 7=J.
- in_rs, in_rt, in_rd, in_shamt  input  5 each  register/shift fields.
- in_funct  input  6  R-type function.
- in_imm  input  16  immediate (LW/SW/ADDI/ORI).
- in_target  input  32  byte target address (BEQ/BNE/J).
- base_load  input  1  reload the address counter.
- base_addr  input  32  new counter value.
- out_valid  output  1  encoded word available.
- out_ready  input  1  consumer takes word when out_valid & out_ready.
- out_instr  output  32  encoded instruction.
- out_addr  output  32  address of out_instr.
- err_valid  output  1  one-cycle error pulse.
- err_code  output  2  1=misaligned target, 2=branch out of range, 3=jump region mismatch.

Function
REQ-003 SHALL use opcodes RTYPE 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ORI 001101, J 000010.
REQ-004 SHALL encode formats:
- R: {op,rs,rt,rd,shamt,funct}.
- I: {op,rs,rt,imm}.
- J: {op,target[27:2]}.
REQ-005 SHALL hold a 32-bit address counter pc; each accepted, error-free request is tagged out_addr=pc, and pc then increments by 4 with modulo-2^32 wrap.
REQ-006 SHALL compute the BEQ/BNE imm as (in_target - (pc+4)) arithmetically shifted right by 2, truncated to 16 bits.
REQ-007 SHALL flag err_code 1 if a BEQ/BNE/J in_target[1:0] != 0.
REQ-008 SHALL flag err_code 2 if the BEQ/BNE signed word offset lies outside [-32768, 32767].
REQ-009 SHALL flag err_code 3 if a J in_target[31:28] != (pc+4)[31:28].
REQ-010 SHALL check errors in the order 1, 2, 3 and report only the first one that fails.
REQ-011 SHALL, on an accepted request that has an error, assert err_valid for exactly the next cycle, enqueue nothing and leave pc unchanged.
REQ-012 SHALL buffer encoded words in a 2-entry FIFO; in_ready=1 only when the FIFO holds fewer than 2 entries, with no same-cycle pass-through when full.
REQ-013 SHALL register outputs: an accepted request appears on out_valid/out_instr/out_addr one cycle after acceptance when the FIFO was empty.
REQ-014 SHALL, when push and pop occur in the same cycle with one entry held, keep occupancy at 1 and present the new word next.
REQ-015 SHALL hold out_instr/out_addr stable while out_valid=1 and out_ready=0.
REQ-016 SHALL, on base_load=1, flush the FIFO, set pc=base_addr, force in_ready=0 that cycle and ignore in_valid.
REQ-017 SHALL give base_load priority over every other event in that cycle.
REQ-018 SHALL ignore in_rd/in_shamt/in_funct for non-R kinds, in_imm for BEQ/BNE/J, and in_target for non-BEQ/BNE/J kinds.

Reset
REQ-019 SHALL, while reset=1, drive asynchronously: pc=BASE_ADDR, FIFO empty, out_valid=0, out_instr=0, out_addr=0, err_valid=0, err_code=0, in_ready=0.
REQ-020 SHALL assert in_ready=1 on the first clock edge after reset deasserts.
REQ-021 SHALL discard buffered words when reset is asserted mid-operation.

Structure
REQ-022 SHALL take the opcode constants, in_kind encoding and err_code encoding from shared package mips_pkg, which the main decoder also uses.
REQ-023 SHALL implement the buffer as sub-module enc_fifo2 (2-entry, 64-bit {addr,instr}, with synchronous flush).

Verification
REQ-024 SHALL cover RTYPE rs=9 rt=10 rd=11 shamt=0 funct=0x20 after reset -> out_instr=0x012A5820, out_addr=0x0.
REQ-025 SHALL cover ADDI rs=0 rt=8 imm=5, then LW rs=8 rt=9 imm=4 -> 0x20080005 @0x0, then 0x8D090004 @0x4.
REQ-026 SHALL cover, with pc=0x8, BEQ rs=8 rt=9 target=0x4 -> 0x1109FFFE @0x8; then J target=0x00400020 -> 0x08100008 @0xC.
REQ-027 SHALL cover BEQ target=0x6 -> err_valid pulse with err_code=1, no output, and pc unchanged; BEQ with pc=0 and target=0x00040004 -> err_code=2.
REQ-028 SHALL cover out_ready=0 with 3 requests offered -> 2 accepted, in_ready=0 thereafter; on release, words drain in order with unchanged addresses.
REQ-029 SHALL cover base_load with base_addr=0x00400000 while 2 words are buffered -> FIFO empty, next accepted word tagged out_addr=0x00400000.
